// File: rtl/fpu_add_scheduler.sv
// fpu_add_scheduler: shares one combinational single-precision adder between
// two requesters. Round-robin grant in IDLE, operands registered onto the
// adder inputs (EXEC), sum captured and returned with the requester id (RESP).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Requester side: reqN_ready is combinational and only ever high
// in IDLE, and the producer may drop valid at any time without effect.
// Response side: once rsp_valid rises, rsp_sum and rsp_id hold steady until
// the edge where rsp_ready is also high.
module fpu_add_scheduler #(
    parameter int TOTAL_SIZE = 32,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [TOTAL_SIZE-1:0] req0_a,
    input  logic [TOTAL_SIZE-1:0] req0_b,
    input  logic                  req0_sub,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [TOTAL_SIZE-1:0] req1_a,
    input  logic [TOTAL_SIZE-1:0] req1_b,
    input  logic                  req1_sub,
    output logic [TOTAL_SIZE-1:0] fpu_a,
    output logic [TOTAL_SIZE-1:0] fpu_b,
    input  logic [TOTAL_SIZE-1:0] fpu_sum,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [TOTAL_SIZE-1:0] rsp_sum,
    output logic [CNT_W-1:0]      ops_count,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic [TOTAL_SIZE-1:0] r_op_a;
    logic [TOTAL_SIZE-1:0] r_op_b;
    logic                  r_id;
    logic                  r_last_grant;
    logic                  r_rsp_valid;
    logic                  r_rsp_id;
    logic [TOTAL_SIZE-1:0] r_rsp_sum;
    logic [CNT_W-1:0]      r_ops_count;

    logic w_idle;
    logic w_grant0;
    logic w_grant1;

    // Round-robin: a lone requester always wins; on a tie the one that was
    // not granted last wins. r_last_grant resets to 1 so req0 wins first.
    assign w_grant0 = req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
    assign w_idle   = (r_state == S_IDLE);

    // Ready is forced low while reset is held, even though state reads IDLE.
    assign req0_ready = rst_n && w_idle && w_grant0;
    assign req1_ready = rst_n && w_idle && w_grant1;

    assign fpu_a     = r_op_a;
    assign fpu_b     = r_op_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign ops_count = r_ops_count;
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

    // Single FSM: grant/issue in IDLE, capture adder sum in EXEC, hold the
    // response in RESP until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_sum    <= '0;
            r_ops_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0) begin
                        r_op_a       <= req0_a;
                        // Subtraction is a - b with the sign of b flipped.
                        r_op_b       <= {req0_b[TOTAL_SIZE-1] ^ req0_sub, req0_b[TOTAL_SIZE-2:0]};
                        r_id         <= 1'b0;
                        r_last_grant <= 1'b0;
                        r_state      <= S_EXEC;
                    end else if (w_grant1) begin
                        r_op_a       <= req1_a;
                        r_op_b       <= {req1_b[TOTAL_SIZE-1] ^ req1_sub, req1_b[TOTAL_SIZE-2:0]};
                        r_id         <= 1'b1;
                        r_last_grant <= 1'b1;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // The adder has had a full cycle on the registered operands.
                    r_rsp_sum   <= fpu_sum;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ops_count <= r_ops_count + CNT_W'(1);
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_add_scheduler.sv
// Testbench for fpu_add_scheduler: directed scenarios, a transaction-level
// reference model compared every cycle, and literal end-of-scenario checks.
// A second instance with CNT_W=2 shares the stimulus for the wrap scenario.
module tb_fpu_add_scheduler;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_sub = 1'b0, req1_sub = 1'b0;
    logic         rsp_ready = 1'b1;

    logic         req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [W-1:0] fpu_a, fpu_b, fpu_sum, rsp_sum;
    logic [15:0]  ops_count;
    logic [1:0]   dbg_state;

    logic         req0_ready2, req1_ready2, rsp_valid2, rsp_id2, busy2;
    logic [W-1:0] fpu_a2, fpu_b2, fpu_sum2, rsp_sum2;
    logic [1:0]   ops_count2;
    logic [1:0]   dbg_state2;

    // Stand-in for the shared adder: exact results for the directed operand
    // pairs, an arbitrary deterministic function otherwise.
    function automatic logic [W-1:0] fake_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] k;
        k = {a, b};
        case (k)
            {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1 + 2 = 3
            {32'h40400000, 32'hBF800000}: return 32'h40000000; // 3 + -1 = 2
            {32'h40000000, 32'h40000000}: return 32'h40800000; // 2 + 2 = 4
            default:                      return a + b;
        endcase
    endfunction

    assign fpu_sum  = fake_add(fpu_a, fpu_b);
    assign fpu_sum2 = fake_add(fpu_a2, fpu_b2);

    fpu_add_scheduler #(.TOTAL_SIZE(W), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sum(fpu_sum),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .ops_count(ops_count), .busy(busy), .dbg_state(dbg_state)
    );

    fpu_add_scheduler #(.TOTAL_SIZE(W), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready2), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready2), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .fpu_a(fpu_a2), .fpu_b(fpu_b2), .fpu_sum(fpu_sum2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_id(rsp_id2), .rsp_sum(rsp_sum2),
        .ops_count(ops_count2), .busy(busy2), .dbg_state(dbg_state2)
    );

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // ---------------- reference model + scoreboard ----------------
    // One in-flight operation at most. exp_q holds {id, sum} for operations
    // accepted but not yet handed to the consumer.
    logic [W:0]   exp_q[$];
    logic         m_busy = 1'b0;
    logic         m_sum_ready = 1'b0;  // response visible from the cycle after accept
    logic         m_last = 1'b1;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [31:0]  m_cnt = '0;

    always @(negedge clk) begin
        logic e_r0, e_r1, e_rv, n;
        logic [W-1:0] a, b;
        logic sub;
        if (!rst_n) begin
            chk("rst_req0_ready", 32'(req0_ready), 32'd0);
            chk("rst_req1_ready", 32'(req1_ready), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_sum", rsp_sum, 32'd0);
            chk("rst_rsp_id", 32'(rsp_id), 32'd0);
            chk("rst_fpu_a", fpu_a, 32'd0);
            chk("rst_fpu_b", fpu_b, 32'd0);
            chk("rst_ops_count", 32'(ops_count), 32'd0);
            chk("rst_ops_count2", 32'(ops_count2), 32'd0);
            m_busy = 1'b0; m_sum_ready = 1'b0; m_last = 1'b1;
            m_a = '0; m_b = '0; m_cnt = '0;
            exp_q.delete();
        end else begin
            e_r0 = !m_busy && req0_valid && (!req1_valid || m_last);
            e_r1 = !m_busy && req1_valid && (!req0_valid || !m_last);
            e_rv = m_busy && m_sum_ready;
            chk("req0_ready", 32'(req0_ready), 32'(e_r0));
            chk("req1_ready", 32'(req1_ready), 32'(e_r1));
            chk("req0_ready2", 32'(req0_ready2), 32'(e_r0));
            chk("req1_ready2", 32'(req1_ready2), 32'(e_r1));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("busy2", 32'(busy2), 32'(m_busy));
            chk("dbg_state_busy", 32'(dbg_state != 2'd0), 32'(m_busy));
            chk("fpu_a", fpu_a, m_a);
            chk("fpu_b", fpu_b, m_b);
            chk("fpu_b2", fpu_b2, m_b);
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            chk("rsp_valid2", 32'(rsp_valid2), 32'(e_rv));
            chk("ops_count", 32'(ops_count), 32'(m_cnt[15:0]));
            chk("ops_count2", 32'(ops_count2), 32'(m_cnt[1:0]));
            if (e_rv && exp_q.size() > 0) begin
                chk("rsp_sum", rsp_sum, exp_q[0][W-1:0]);
                chk("rsp_id", 32'(rsp_id), 32'(exp_q[0][W]));
                chk("rsp_sum2", rsp_sum2, exp_q[0][W-1:0]);
                chk("rsp_id2", 32'(rsp_id2), 32'(exp_q[0][W]));
            end
            // what the next rising edge does
            if (e_r0 || e_r1) begin
                n   = e_r1;
                a   = n ? req1_a : req0_a;
                b   = n ? req1_b : req0_b;
                sub = n ? req1_sub : req0_sub;
                m_a = a;
                m_b = {b[W-1] ^ sub, b[W-2:0]};
                exp_q.push_back({n, fake_add(m_a, m_b)});
                m_last = n;
                m_busy = 1'b1;
                m_sum_ready = 1'b0;
            end else if (m_busy && !m_sum_ready) begin
                m_sum_ready = 1'b1;
            end else if (e_rv && rsp_ready) begin
                void'(exp_q.pop_front());
                m_busy = 1'b0;
                m_sum_ready = 1'b0;
                m_cnt = m_cnt + 32'd1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic sub);
        if (n == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_sub = sub;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_sub = sub;
        end
    endtask

    task automatic wait_ready(input int n, output bit ok);
        ok = 1'b0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) timeout("wait_ready");
    endtask

    task automatic wait_rsp(output logic [W-1:0] s, output logic id, output int cyc);
        bit ok;
        ok = 1'b0;
        cyc = 0;
        s = '0;
        id = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                s = rsp_sum;
                id = rsp_id;
                break;
            end
            tick();
            cyc++;
        end
        if (!ok) timeout("wait_rsp");
    endtask

    // Issue one operation, return the response and the fpu_b seen in EXEC.
    task automatic do_op(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, output logic [W-1:0] s, output logic id,
                         output logic [W-1:0] fb, output int cyc);
        bit ok;
        set_req(n, 1'b1, a, b, sub);
        wait_ready(n, ok);
        tick();                       // accept edge
        set_req(n, 1'b0, '0, '0, 1'b0);
        fb = fpu_b;
        wait_rsp(s, id, cyc);
        tick();                       // handshake edge when rsp_ready is high
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [W-1:0] s, fb, s0;
        logic id, i0, g;
        int cyc;
        bit ok;
        logic [15:0] cnt0;
        logic [1:0] grant_exp[4];
        logic [1:0] wrap_exp[5];
        logic [1:0] grants[4];

        grant_exp = '{2'd0, 2'd1, 2'd0, 2'd1};
        wrap_exp  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        do_reset();

        // single add 1.0 + 2.0
        rsp_ready = 1'b1;
        do_op(0, 32'h3F800000, 32'h40000000, 1'b0, s, id, fb, cyc);
        chk("add_sum", s, 32'h40400000);
        chk("add_id", 32'(id), 32'd0);
        chk("add_latency", 32'(cyc), 32'd1);
        chk("add_ops_count", 32'(ops_count), 32'd1);

        // subtract 3.0 - 1.0 from req1
        do_op(1, 32'h40400000, 32'h3F800000, 1'b1, s, id, fb, cyc);
        chk("sub_fpu_b", fb, 32'hBF800000);
        chk("sub_sum", s, 32'h40000000);
        chk("sub_id", 32'(id), 32'd1);

        // backpressure: consumer stalls 5 cycles while req1 is waiting
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 32'h40000000, 32'h40000000, 1'b0);
        wait_ready(0, ok);
        tick();
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b1, 32'h12345678, 32'h00000001, 1'b0);
        wait_rsp(s0, i0, cyc);
        cnt0 = ops_count;
        chk("bp_sum", s0, 32'h40800000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_sum_stable", rsp_sum, s0);
            chk("bp_id_stable", 32'(rsp_id), 32'(i0));
            chk("bp_valid_held", 32'(rsp_valid), 32'd1);
            chk("bp_req0_ready", 32'(req0_ready), 32'd0);
            chk("bp_req1_ready", 32'(req1_ready), 32'd0);
        end
        set_req(1, 1'b0, '0, '0, 1'b0);
        rsp_ready = 1'b1;
        tick();
        chk("bp_count_once", 32'(ops_count), 32'(cnt0 + 16'd1));
        tick();
        tick();
        chk("bp_count_after", 32'(ops_count), 32'(cnt0 + 16'd1));

        // contention from reset: both requesters valid continuously
        do_reset();
        set_req(0, 1'b1, 32'h3F800000, 32'h40000000, 1'b0);
        set_req(1, 1'b1, 32'h40400000, 32'h3F800000, 1'b1);
        #1;
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            g = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (req0_ready || req1_ready) begin
                    ok = 1'b1;
                    g = req1_ready;
                    break;
                end
                tick();
            end
            if (!ok) timeout("contend_grant");
            grants[k] = {1'b0, g};
            tick();
        end
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0);
        tick(); tick(); tick();
        for (int k = 0; k < 4; k++) chk("contend_order", 32'(grants[k]), 32'(grant_exp[k]));
        chk("contend_count", 32'(ops_count), 32'd4);

        // reset asserted while in EXEC
        set_req(0, 1'b1, 32'h3F800000, 32'h40000000, 1'b0);
        wait_ready(0, ok);
        tick();
        set_req(0, 1'b0, '0, '0, 1'b0);
        chk("mid_busy_before", 32'(busy), 32'd1);
        set_req(1, 1'b1, 32'h11111111, 32'h22222222, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_fpu_a", fpu_a, 32'd0);
        chk("mid_ops_count", 32'(ops_count), 32'd0);
        chk("mid_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        set_req(1, 1'b0, '0, '0, 1'b0);
        tick(); tick(); tick();
        chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
        set_req(0, 1'b1, 32'h3F800000, 32'h40000000, 1'b0);
        set_req(1, 1'b1, 32'h40400000, 32'h3F800000, 1'b1);
        #1;
        chk("mid_first_grant0", 32'(req0_ready), 32'd1);
        chk("mid_first_grant1", 32'(req1_ready), 32'd0);
        tick();
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0);
        tick(); tick(); tick();

        // counter wrap on the CNT_W=2 instance
        do_reset();
        for (int k = 0; k < 5; k++) begin
            do_op(0, 32'h00000010 + 32'(k), 32'h00000100, 1'b0, s, id, fb, cyc);
            chk("wrap_count2", 32'(ops_count2), 32'(wrap_exp[k]));
        end
        chk("wrap_count16", 32'(ops_count), 32'd5);

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
